// File: rtl/addr_stack_pkg.sv
// -----------------------------------------------------------------------------
// addr_stack_pkg
// Shared types and default sizes for the 4004 address-stack controller.
//   cmd_e   : 3-bit sequencer opcode (codes 5-7 are unused and act as NOP)
//   state_e : controller FSM state
// Optional feature macro used by the slice: ADDR_STACK_DEPTH_CHECK_EN
// -----------------------------------------------------------------------------
package addr_stack_pkg;

    localparam int DEF_ADDR_W = 12;  // PC and stack entry width
    localparam int DEF_PTR_W  = 2;   // stack pointer width (RAM depth 4)

    typedef enum logic [2:0] {
        CMD_NOP  = 3'd0,
        CMD_INC  = 3'd1,
        CMD_LOAD = 3'd2,
        CMD_PUSH = 3'd3,
        CMD_POP  = 3'd4
    } cmd_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PUSH_WR = 2'd1,
        ST_POP_RD  = 2'd2,
        ST_POP_CAP = 2'd3
    } state_e;

endpackage

// File: rtl/addr_stack_ptr.sv
// -----------------------------------------------------------------------------
// addr_stack_ptr
// Stack pointer for the address-stack RAM plus optional nesting-depth tracking.
// Ports:
//   clock, reset     : clock, asynchronous active-high reset
//   inc_i            : push committed this cycle (pointer advances)
//   dec_i            : pop committed this cycle (pointer retreats)
//   sp_o             : current pointer (next free entry)
//   sp_m1_o          : pointer minus one (most recent entry)
//   ovf_o / unf_o    : sticky overflow / underflow flags
// Macro ADDR_STACK_DEPTH_CHECK_EN: when defined, a depth counter drives the
// flags; when undefined, the flags are tied low. The pointer always wraps.
// -----------------------------------------------------------------------------
module addr_stack_ptr #(
    parameter int PTR_W  = 2,
    parameter int LEVELS = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc_i,
    input  logic             dec_i,
    output logic [PTR_W-1:0] sp_o,
    output logic [PTR_W-1:0] sp_m1_o,
    output logic             ovf_o,
    output logic             unf_o
);

    logic [PTR_W-1:0] sp_q;

    // NOTE: sequential state is updated with non-blocking assignments only, so
    // every flop samples the pre-edge value of every other flop.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sp_q <= '0;
        end else if (inc_i) begin
            sp_q <= sp_q + PTR_W'(1);
        end else if (dec_i) begin
            sp_q <= sp_q - PTR_W'(1);
        end
    end

    assign sp_o    = sp_q;
    assign sp_m1_o = sp_q - PTR_W'(1);

`ifdef ADDR_STACK_DEPTH_CHECK_EN
    localparam int DEPTH_W = $clog2(LEVELS + 1);

    logic [DEPTH_W-1:0] depth_q;
    logic               ovf_q;
    logic               unf_q;

    // Depth saturates at both ends; the offending push/pop still moves the
    // pointer (wrap/stale read), it only raises the sticky flag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            depth_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else if (inc_i) begin
            if (depth_q == DEPTH_W'(LEVELS)) begin
                ovf_q <= 1'b1;
            end else begin
                depth_q <= depth_q + DEPTH_W'(1);
            end
        end else if (dec_i) begin
            if (depth_q == '0) begin
                unf_q <= 1'b1;
            end else begin
                depth_q <= depth_q - DEPTH_W'(1);
            end
        end
    end

    assign ovf_o = ovf_q;
    assign unf_o = unf_q;
`else
    // Depth tracking is compiled out; LEVELS only matters for the checked build.
    localparam int unused_levels = LEVELS;

    assign ovf_o = 1'b0;
    assign unf_o = 1'b0;
`endif

endmodule

// File: rtl/addr_stack_ctrl.sv
// -----------------------------------------------------------------------------
// addr_stack_ctrl
// Controller for the 4-entry x 12-bit synchronous address-stack RAM of the
// 4004 core. Owns the live PC (shadow register) and the stack pointer, and
// executes INC / LOAD / PUSH (JMS) / POP (BBL) commands from the sequencer.
// Ports:
//   clock, reset           : clock, asynchronous active-high reset
//   cmd_valid/cmd_ready    : command handshake (ready only in IDLE)
//   cmd_op, cmd_target     : opcode (addr_stack_pkg::cmd_e) and LOAD/PUSH target
//   pc_out                 : current program counter
//   mem_addr, mem_wdata    : RAM address / write data
//   mem_wren, mem_sel      : RAM write enable / output select (never both 1)
//   mem_rdata              : RAM read data, valid one cycle after the address edge
//   stack_ovf, stack_unf   : sticky overflow / underflow flags
// Macro ADDR_STACK_DEPTH_CHECK_EN enables depth tracking and the flags.
// -----------------------------------------------------------------------------
module addr_stack_ctrl
    import addr_stack_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int PTR_W      = DEF_PTR_W,
    parameter int LEVELS     = 3,
    parameter int RET_OFFSET = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_target,
    output logic [ADDR_W-1:0] pc_out,
    output logic [PTR_W-1:0]  mem_addr,
    output logic [ADDR_W-1:0] mem_wdata,
    output logic              mem_wren,
    output logic              mem_sel,
    input  logic [ADDR_W-1:0] mem_rdata,
    output logic              stack_ovf,
    output logic              stack_unf
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q,  pc_d;
    logic [ADDR_W-1:0] ret_q, ret_d;   // return address latched at PUSH accept
    logic [ADDR_W-1:0] tgt_q, tgt_d;   // jump target latched at PUSH accept
    logic              push_done;
    logic              pop_done;
    logic [PTR_W-1:0]  sp;
    logic [PTR_W-1:0]  sp_m1;

    addr_stack_ptr #(
        .PTR_W  (PTR_W),
        .LEVELS (LEVELS)
    ) u_ptr (
        .clock   (clock),
        .reset   (reset),
        .inc_i   (push_done),
        .dec_i   (pop_done),
        .sp_o    (sp),
        .sp_m1_o (sp_m1),
        .ovf_o   (stack_ovf),
        .unf_o   (stack_unf)
    );

    // NOTE: every signal assigned here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ret_d     = ret_q;
        tgt_d     = tgt_q;
        push_done = 1'b0;
        pop_done  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    case (cmd_e'(cmd_op))
                        CMD_INC:  pc_d = pc_q + ADDR_W'(1);
                        CMD_LOAD: pc_d = cmd_target;
                        CMD_PUSH: begin
                            ret_d   = pc_q + ADDR_W'(RET_OFFSET);
                            tgt_d   = cmd_target;
                            state_d = ST_PUSH_WR;
                        end
                        CMD_POP:  state_d = ST_POP_RD;
                        default:  ;  // NOP and unused codes 5-7
                    endcase
                end
            end
            ST_PUSH_WR: begin
                pc_d      = tgt_q;
                push_done = 1'b1;
                state_d   = ST_IDLE;
            end
            ST_POP_RD: begin
                state_d = ST_POP_CAP;
            end
            ST_POP_CAP: begin
                // RAM data for the address driven in POP_RD is valid now.
                pc_d     = mem_rdata;
                pop_done = 1'b1;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            ret_q   <= '0;
            tgt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ret_q   <= ret_d;
            tgt_q   <= tgt_d;
        end
    end

    // RAM interface decodes straight from the registered state, so an
    // asynchronous reset drops wren/sel in the same instant.
    assign cmd_ready = (state_q == ST_IDLE);
    assign mem_wren  = (state_q == ST_PUSH_WR);
    assign mem_sel   = (state_q == ST_POP_RD) || (state_q == ST_POP_CAP);
    assign mem_addr  = mem_wren ? sp    :
                       mem_sel  ? sp_m1 : '0;
    assign mem_wdata = mem_wren ? ret_q : '0;
    assign pc_out    = pc_q;

endmodule

// File: doc/addr_stack_ctrl.md
Name: addr_stack_ctrl

Overview:
- Initiator/controller for the 4-entry x 12-bit synchronous address-stack RAM of the 4004 core.
- Holds the live program counter in a shadow register and owns the 2-bit stack pointer.
- Executes PC increment, jump-load, push (JMS) and pop (BBL) commands from the instruction sequencer.
- Drives the RAM's address, write data, write enable and output select; captures the RAM's read data.

Parameters:
- ADDR_W, 12, PC and stack entry width.
- PTR_W, 2, stack pointer width (RAM depth = 2**PTR_W = 4).
- LEVELS, 3, architectural nesting depth used for overflow/underflow detection.
- RET_OFFSET, 2, added to PC to form the return address saved on push.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  controller can accept a command
- cmd_op  in  3  opcode (addr_stack_pkg::cmd_e)
- cmd_target  in  12  target address for LOAD/PUSH
- pc_out  out  12  current program counter (shadow register)
- mem_addr  out  2  RAM address
- mem_wdata  out  12  RAM write data
- mem_wren  out  1  RAM write enable
- mem_sel  out  1  RAM output select (read enable)
- mem_rdata  in  12  RAM read data, valid 1 cycle after address edge
- stack_ovf  out  1  sticky overflow flag
- stack_unf  out  1  sticky underflow flag

Behaviour:
- Reset (async, any state):
  - pc_out=0, sp=0, depth=0; state=IDLE.
  - cmd_ready=1, mem_wren=0, mem_sel=0, mem_addr=0, mem_wdata=0.
  - stack_ovf=0, stack_unf=0.
- Accept: cmd_valid & cmd_ready at a clock edge. cmd_ready=1 only in IDLE.
- Opcodes: NOP=0, INC=1, LOAD=2, PUSH=3, POP=4; codes 5-7 are treated as NOP.
- All PC arithmetic is modulo 2**ADDR_W; the pointer wraps modulo 4.
- FSM states: IDLE, PUSH_WR, POP_RD, POP_CAP.
- IDLE:
  - INC: pc <= pc+1 at the accept edge; stays in IDLE; 1 cycle.
  - LOAD: pc <= cmd_target; stays in IDLE.
  - PUSH: latch ret=pc+RET_OFFSET and target; go to PUSH_WR.
  - POP: go to POP_RD.
  - NOP: no effect.
- PUSH_WR (1 cycle):
  - Drives mem_addr=sp, mem_wdata=ret, mem_wren=1, cmd_ready=0.
  - At the exit edge: sp<=sp+1, pc<=target, depth<=min(depth+1,LEVELS); next state IDLE.
  - Total: 2 cycles from accept to the next accept.
- POP_RD (1 cycle):
  - Drives mem_addr=sp-1, mem_sel=1, mem_wren=0, cmd_ready=0; next state POP_CAP.
- POP_CAP (1 cycle):
  - Keeps mem_sel=1 and mem_addr=sp-1.
  - At the exit edge: pc<=mem_rdata, sp<=sp-1, depth<=max(depth-1,0); next state IDLE.
  - Total: 3 cycles accept-to-accept; pc_out updated 2 edges after accept.
- Memory outputs are combinational from the registered state and latched operands; mem_wren and mem_sel are never both 1.
- Boundary conditions:
  - PUSH with depth==LEVELS: write still performed (wraps and overwrites the oldest entry); sets stack_ovf; depth stays LEVELS.
  - POP with depth==0: read still performed at sp-1 (stale data loaded into pc); sets stack_unf; depth stays 0.
  - Flags are sticky until reset.
  - cmd_valid while cmd_ready=0 is ignored; the sequencer holds its command until accepted.
  - Reset mid-PUSH_WR or mid-POP: the write/read is aborted immediately and no state is committed.

Optional Feature:
- Macro ADDR_STACK_DEPTH_CHECK_EN.
- Defined: depth counter, stack_ovf and stack_unf are implemented as described above.
- Undefined: no depth counter; stack_ovf and stack_unf are tied to 0; all stack operations are otherwise identical, including wrap behaviour.

Decomposition:
- addr_stack_pkg holds:
  - cmd_e opcode enum (3-bit);
  - state_e FSM enum;
  - ADDR_W and PTR_W default constants.
- Sub-module addr_stack_ptr: pointer plus depth/flag logic. Inputs: inc/dec strobes. Outputs: sp, sp_minus1, ovf, unf.
- The FSM and PC shadow register stay in the top module.

Test Plan:
- Reset, then INC x3 -> pc_out=0x003; cmd_ready stays 1 throughout.
- LOAD 0x0FF, then PUSH target 0x400 -> PUSH_WR cycle shows mem_addr=0, mem_wdata=0x101, mem_wren=1; then pc_out=0x400, sp=1.
- Continuing from the previous scenario, POP -> mem_addr=0 with mem_sel=1 for 2 cycles; pc_out=0x101 on the 2nd edge after accept; cmd_ready low for 2 cycles.
- LOAD 0xFFF, INC -> pc_out=0x000 (wrap); PUSH at pc=0xFFF -> mem_wdata=0x001.
- Four PUSHes from reset -> stack_ovf=1 after the 4th (macro defined), 0 (macro undefined); fifth PUSH writes mem_addr=0. Four POPs from reset -> stack_unf=1 (macro defined).
- Assert reset during POP_RD -> mem_sel=0 immediately, pc_out=0, sp=0, cmd_ready=1 asynchronously.
